// File: rtl/exec_pipe_datapath.sv
// Two-stage execute datapath: register file, operand bypass, 8-op ALU and a
// result stage with valid/ready backpressure toward memory/writeback.
module exec_pipe_datapath #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic                     RegWrite,
  input  logic                     ALUsrc,
  input  logic [2:0]               ALUctrl,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUout,
  output logic                     EQ,
  output logic [DATA_WIDTH-1:0]    a0
);
  localparam int NREG = 2**ADDRESS_WIDTH;
  localparam int SHW  = $clog2(DATA_WIDTH);

  // operand stage
  typedef struct packed {
    logic                     vld;
    logic [DATA_WIDTH-1:0]    op1;
    logic [DATA_WIDTH-1:0]    op2;
    logic [DATA_WIDTH-1:0]    imm;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     we;
    logic                     src;
    logic [2:0]               ctl;
  } s1_t;

  // result stage
  typedef struct packed {
    logic                     vld;
    logic [DATA_WIDTH-1:0]    res;
    logic                     eq;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     we;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic [DATA_WIDTH-1:0] rf_q [NREG];

  logic                  stall, commit;
  logic [DATA_WIDTH-1:0] op2sel, res_d;
  logic                  eq_d;
  logic [SHW-1:0]        shamt;

  // lane 0 = rs1, lane 1 = rs2
  logic [1:0][ADDRESS_WIDTH-1:0] src_idx;
  logic [1:0][DATA_WIDTH-1:0]    fwd;

  assign stall     = s2_q.vld && !out_ready;
  assign in_ready  = !stall;
  assign commit    = s2_q.vld && out_ready && s2_q.we && (s2_q.rd != '0);
  assign src_idx   = {rs2, rs1};
  assign out_valid = s2_q.vld;
  assign ALUout    = s2_q.res;
  assign EQ        = s2_q.eq;
  assign a0        = rf_q[10];

  // ALU on the S1 operands; EQ compares regardless of the selected op
  always_comb begin
    res_d  = '0;
    op2sel = s1_q.src ? s1_q.op2 : s1_q.imm;
    shamt  = op2sel[SHW-1:0];
    eq_d   = (s1_q.op1 == op2sel);
    case (s1_q.ctl)
      3'b000:  res_d = s1_q.op1 + op2sel;
      3'b001:  res_d = s1_q.op1 - op2sel;
      3'b010:  res_d = s1_q.op1 & op2sel;
      3'b011:  res_d = s1_q.op1 | op2sel;
      3'b100:  res_d = s1_q.op1 ^ op2sel;
      3'b101:  res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(s1_q.op1) < $signed(op2sel))};
      3'b110:  res_d = s1_q.op1 << shamt;
      default: res_d = s1_q.op1 >> shamt;
    endcase
  end

  // operand bypass: youngest producer (S1's live ALU result) wins over S2,
  // S2 wins over the regfile; x0 is never forwarded
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fwd[i] = rf_q[src_idx[i]];
      if (src_idx[i] == '0)
        fwd[i] = '0;
      else if (s1_q.vld && s1_q.we && s1_q.rd == src_idx[i])
        fwd[i] = res_d;
      else if (s2_q.vld && s2_q.we && s2_q.rd == src_idx[i])
        fwd[i] = s2_q.res;
    end
  end

  // pipeline advance: both stages freeze on stall, otherwise shift forward
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (!stall) begin
      s2_d.vld = s1_q.vld;
      s2_d.res = res_d;
      s2_d.eq  = eq_d;
      s2_d.rd  = s1_q.rd;
      s2_d.we  = s1_q.we;
      s1_d.vld = in_valid;
      if (in_valid) begin
        s1_d.op1 = fwd[0];
        s1_d.op2 = fwd[1];
        s1_d.imm = ImmOp;
        s1_d.rd  = rd;
        s1_d.we  = RegWrite;
        s1_d.src = ALUsrc;
        s1_d.ctl = ALUctrl;
      end
    end
  end

  // stage registers; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // register file write on commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (commit) begin
      rf_q[s2_q.rd] <= s2_q.res;
    end
  end
endmodule

// File: tb/tb_exec_pipe_datapath.sv
// Bench for exec_pipe_datapath: directed scenarios plus random traffic, checked
// against an architectural model (program-order regfile + committed regfile).
module tb_exec_pipe_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        RegWrite = 1'b0, ALUsrc = 1'b0;
  logic [2:0]  ALUctrl = '0;
  logic [31:0] ImmOp = '0;
  logic        out_valid, out_ready = 1'b0, EQ;
  logic [31:0] ALUout, a0;

  int checks = 0;
  int fails  = 0;

  // model: arf = value each register holds once all accepted work retires,
  // crf = what has actually been committed; m1/m2 = in-flight results
  logic [31:0] arf [32];
  logic [31:0] crf [32];
  int          m1_v, m2_v, m1_we, m2_we, m1_rd, m2_rd;
  logic [31:0] m1_res, m2_res;
  logic        m1_eq, m2_eq;

  exec_pipe_datapath #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .ImmOp(ImmOp), .out_valid(out_valid), .out_ready(out_ready),
    .ALUout(ALUout), .EQ(EQ), .a0(a0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu(input int ctl, input logic [31:0] a, input logic [31:0] b);
    case (ctl)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic int pick();
    int t = int'($urandom_range(0, 4));
    return (t == 4) ? 10 : t;
  endfunction

  // one clock: drive at negedge, check, advance model, wait for next negedge
  task automatic cyc(input int iv, input int r1, input int r2, input int rdd, input int we,
                     input int src, input int ctl, input logic [31:0] imm, input int ordy);
    logic [31:0] a, b, bs;
    int stall;
    in_valid  = (iv != 0);
    rs1       = 5'(r1);
    rs2       = 5'(r2);
    rd        = 5'(rdd);
    RegWrite  = (we != 0);
    ALUsrc    = (src != 0);
    ALUctrl   = 3'(ctl);
    ImmOp     = imm;
    out_ready = (ordy != 0);
    #1;
    chk("in_ready", 32'(in_ready), 32'((m2_v != 0 && ordy == 0) ? 0 : 1));
    chk("out_valid", 32'(out_valid), 32'(m2_v));
    if (m2_v != 0) begin
      chk("ALUout", ALUout, m2_res);
      chk("EQ", 32'(EQ), 32'(m2_eq));
    end
    chk("a0", a0, crf[10]);
    stall = (m2_v != 0 && ordy == 0) ? 1 : 0;
    if (stall == 0) begin
      if (m2_v != 0 && m2_we != 0 && m2_rd != 0) crf[m2_rd] = m2_res;
      m2_v = m1_v; m2_res = m1_res; m2_eq = m1_eq; m2_rd = m1_rd; m2_we = m1_we;
      m1_v = iv;
      if (iv != 0) begin
        a  = (r1 == 0) ? 32'd0 : arf[r1];
        b  = (r2 == 0) ? 32'd0 : arf[r2];
        bs = (src != 0) ? b : imm;
        m1_res = alu(ctl, a, bs);
        m1_eq  = (a == bs);
        m1_rd  = rdd;
        m1_we  = we;
        if (we != 0 && rdd != 0) arf[rdd] = m1_res;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin arf[i] = '0; crf[i] = '0; end
    m1_v = 0; m2_v = 0; m1_we = 0; m2_we = 0; m1_rd = 0; m2_rd = 0;
    m1_res = '0; m2_res = '0; m1_eq = 1'b0; m2_eq = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a0", a0, 32'd0);
    chk("rst_ALUout", ALUout, 32'd0);
    chk("rst_EQ", 32'(EQ), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // issue one op into an empty-ish pipe, then look at S2 one cycle later
  task automatic corner(input string tag, input int r1, input int r2, input int src,
                        input int ctl, input logic [31:0] imm,
                        input logic [31:0] er, input logic ee);
    cyc(1, r1, r2, 12, 1, src, ctl, imm, 1);
    idle(1);
    chk({tag, "_res"}, ALUout, er);
    chk({tag, "_eq"}, 32'(EQ), 32'(ee));
  endtask

  initial begin
    do_reset(2);

    // immediate add into x10
    cyc(1, 0, 0, 10, 1, 0, 0, 32'd5, 1);
    idle(1);
    chk("addi_ALUout", ALUout, 32'd5);
    idle(1);
    chk("addi_a0", a0, 32'd5);

    // back-to-back dependency through S1 forwarding
    cyc(1, 0, 0, 1, 1, 0, 0, 32'd7, 1);
    cyc(1, 1, 1, 2, 1, 1, 0, 32'd0, 1);
    chk("b2b_first", ALUout, 32'd7);
    idle(1);
    chk("b2b_second", ALUout, 32'd14);
    chk("b2b_nobubble", 32'(out_valid), 32'd1);
    idle(2);

    // backpressure: three x10+=1 with out_ready low for four cycles
    cyc(1, 10, 0, 10, 1, 0, 0, 32'd1, 0);
    cyc(1, 10, 0, 10, 1, 0, 0, 32'd1, 0);
    chk("bp_first", ALUout, 32'd6);
    cyc(1, 10, 0, 10, 1, 0, 0, 32'd1, 0);
    chk("bp_frozen", ALUout, 32'd6);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    cyc(1, 10, 0, 10, 1, 0, 0, 32'd1, 0);
    chk("bp_frozen2", ALUout, 32'd6);
    chk("bp_a0_hold", a0, 32'd5);
    cyc(1, 10, 0, 10, 1, 0, 0, 32'd1, 1);
    chk("bp_rel_1", ALUout, 32'd7);
    chk("bp_a0_1", a0, 32'd6);
    idle(1);
    chk("bp_rel_2", ALUout, 32'd8);
    chk("bp_a0_2", a0, 32'd7);
    idle(1);
    chk("bp_a0_3", a0, 32'd8);
    idle(1);
    chk("bp_a0_once", a0, 32'd8);

    // ALU corners
    cyc(1, 0, 0, 3, 1, 0, 0, 32'hFFFF_FFFF, 1);
    cyc(1, 0, 0, 5, 1, 0, 0, 32'h8000_0000, 1);
    cyc(1, 0, 0, 6, 1, 0, 0, 32'd1, 1);
    cyc(1, 0, 0, 7, 1, 0, 0, 32'd5, 1);
    corner("add_wrap", 3, 0, 0, 0, 32'd1, 32'd0, 1'b0);
    corner("slt_neg", 5, 0, 0, 5, 32'd1, 32'd1, 1'b0);
    corner("sll_33", 6, 0, 0, 6, 32'd33, 32'd2, 1'b0);
    corner("srl_31", 5, 0, 0, 7, 32'd31, 32'd1, 1'b0);
    corner("sub_eq", 7, 7, 1, 1, 32'd0, 32'd0, 1'b1);

    // writes to x0 are discarded and never forwarded
    cyc(1, 0, 0, 0, 1, 0, 0, 32'd9, 1);
    cyc(1, 0, 0, 11, 1, 1, 0, 32'd0, 1);
    idle(1);
    chk("x0_read", ALUout, 32'd0);
    idle(2);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 3) != 0) ? 1 : 0, pick(), pick(), pick(),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 3) != 0) ? 1 : 0);
    end
    idle(3);

    // reset with S1 and S2 both holding x10 writers
    do_reset(2);
    cyc(1, 0, 0, 10, 1, 0, 0, 32'd77, 1);
    cyc(1, 0, 0, 10, 1, 0, 0, 32'd88, 1);
    chk("mid_s2_valid", 32'(out_valid), 32'd1);
    do_reset(1);
    idle(3);
    chk("mid_a0", a0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/exec_pipe_datapath.md
# exec_pipe_datapath

Parametrised two-stage execute datapath for the single-issue core: register file, operand bypass, an 8-operation ALU and a result stage with valid/ready backpressure. It generalises the single-cycle register-file/ALU/immediate-select path: configurable width and register count, a registered pipeline, hazard forwarding and a stall handshake toward the downstream stage. It sits between decode, which supplies register indices, immediate and controls, and the memory/writeback stage.

## Interface
- DATA_WIDTH, 32, datapath and register width; power of two, at least 8.
- ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH registers; at least 4, so x10 exists.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  block accepts the instruction this cycle.
- rs1, rs2, rd  in  ADDRESS_WIDTH each  source and destination register indices.
- RegWrite  in  1  instruction writes rd.
- ALUsrc  in  1  1 = operand 2 from rs2; 0 = operand 2 from ImmOp.
- ALUctrl  in  3  ALU operation.
- ImmOp  in  DATA_WIDTH  sign-extended immediate.
- out_valid  out  1  S2 holds a result.
- out_ready  in  1  downstream accepts the S2 result.
- ALUout  out  DATA_WIDTH  S2 result.
- EQ  out  1  S2 flag: operand1 == selected operand2.
- a0  out  DATA_WIDTH  committed contents of x10.

## Operation
- x0 reads as 0; writes to x0 are discarded.
- S1 (operand register) holds valid, op1, op2 (rs2 value), imm, rd, RegWrite, ALUsrc, ALUctrl.
- S2 (result register) holds valid, result, EQ, rd, RegWrite.
- stall = out_valid && !out_ready; in_ready = !stall.
- Accept when in_valid && in_ready: S1 loads the forwarded operands and controls, S1.valid=1. If !in_valid && in_ready: S1.valid=0. During stall, S1 and S2 hold.
- Whenever !stall, S2 loads the ALU output computed from S1, with S2.valid = S1.valid.
- Commit: at an edge with S2.valid && out_ready && S2.RegWrite && S2.rd != 0, the regfile writes S2.result to S2.rd.
- Forwarding, per source operand, when the index is nonzero, in priority order:
  - S1 valid, S1.RegWrite and S1.rd matches: take the combinational ALU result of S1.
  - Else S2 valid, S2.RegWrite and S2.rd matches: take S2.result.
  - Else: take the regfile value.
- ALU: op2sel = ALUsrc ? op2 : imm.
  - 000 add; 001 sub; 010 and; 011 or; 100 xor.
  - 101 signed less-than, result 1 or 0, zero-extended.
  - 110 shift left logical by op2sel[log2(DATA_WIDTH)-1:0]; 111 shift right logical by the same amount.
  - add and sub wrap modulo 2**DATA_WIDTH, with no overflow flag.
- EQ = (op1 == op2sel), independent of ALUctrl.
- a0 is the regfile x10 output, so it changes only on commit.

## Timing
- Reset:
  - All registers are 0.
  - S1.valid, S2.valid and out_valid are 0; ALUout, EQ and a0 are 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset during a stall or in mid-pipeline discards all in-flight instructions with no commit, and overrides in_valid and out_ready.
- Latency:
  - Accepted at edge k: result on ALUout with out_valid=1 after edge k+1, when the pipe is not stalled.
  - Commit at the first edge ≥ k+2 where out_ready=1; a0 updates after that edge.
- Throughput is one instruction per cycle with out_ready held high. Back-to-back dependent instructions issue without bubbles.
- out_valid/ALUout/EQ stay stable while out_valid && !out_ready.
- A reader of x10 sees a0 only after commit, never a forwarded value.

## Test plan
- Reset with rst=1 for 2 cycles -> out_valid=0, a0=0, ALUout=0, in_ready=1.
- Immediate add, rd=10, rs1=0, ALUsrc=0, ImmOp=5, ALUctrl=000, out_ready=1 -> ALUout=5 one cycle after accept; a0=5 one cycle later.
- Back-to-back dependency: x1=0+7 via immediate, then x2 = x1 + x1 (ALUsrc=1) next cycle -> second ALUout=14 with no bubble; S1 forwarding priority exercised.
- Backpressure: issue 3 adds with out_ready=0 for 4 cycles -> in_ready=0 while stalled, ALUout frozen at the first result. Release -> results emerge in order, one per cycle, each committed once.
- ALU corners at DATA_WIDTH=32:
  - 0xFFFFFFFF + 1 -> 0.
  - slt(0x80000000, 1) -> 1.
  - sll(1, imm=33) -> 2, since shift uses the low 5 bits.
  - srl(0x80000000, 31) -> 1.
  - 5 - 5 -> 0 with EQ=1.
- x0 and reset mid-flight:
  - Write 9 to rd=0 -> later read of x0 gives 0, with no forward.
  - Assert rst while S1 and S2 are valid -> no commit, and a0 keeps its reset value of 0.
